// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default sizing.
// Pure definitions only, no logic; imported by the sequencer and its command FIFO.
// WIDTH/TIMEOUT defaults match the 3-bit up-counter this block drives.
package counter_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_TIMEOUT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Two-entry command FIFO with a registered push-ready flag.
// Latency: an entry pushed on one edge is visible at the head from the next cycle.
// Backpressure: push_rdy drops the cycle after the FIFO fills and rises the cycle after a pop.
module cmd_fifo #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);
    assign head_dat = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (do_pop && !do_push) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Ready is registered, so it is computed from the count we are about to hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
            push_rdy <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt      <= cnt_nxt;
            push_rdy <= (cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences buffered start-value commands through the up-counter and reports increment counts.
// Latency: load two cycles after accept into an idle empty queue; response the cycle after done.
// Backpressure: cmd_ready follows the 2-entry queue; RESP holds until rsp_ready.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_value,
    output logic             load,
    output logic [WIDTH-1:0] in,
    output logic             inc,
    input  logic             done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CW-1:0]    rsp_count,
    output logic             rsp_err
);

    state_t           state;
    logic [CW-1:0]    inc_cnt;
    logic [CW-1:0]    inc_cnt_nxt;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;

    cmd_fifo #(.W(WIDTH)) u_cmd_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (cmd_valid),
        .push_rdy (cmd_ready),
        .push_dat (cmd_value),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty)
    );

    assign fifo_pop = (state == IDLE) && !fifo_empty;

    // inc is the only combinational output: the counter must stop the same cycle done rises.
    assign inc = (state == RUN) && !done;

    assign inc_cnt_nxt = (inc_cnt == CW'(TIMEOUT)) ? inc_cnt : inc_cnt + CW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            load      <= 1'b0;
            in        <= '0;
            inc_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_count <= '0;
            rsp_err   <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        in    <= fifo_head;
                        load  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    inc_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (done) begin
                        rsp_valid <= 1'b1;
                        rsp_count <= inc_cnt;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (inc_cnt_nxt == CW'(TIMEOUT)) begin
                        inc_cnt   <= inc_cnt_nxt;
                        rsp_valid <= 1'b1;
                        rsp_count <= inc_cnt_nxt;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        inc_cnt <= inc_cnt_nxt;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural 3-bit up-counter.
module tb_counter_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_value;
    logic       load;
    logic [2:0] in_v;
    logic       inc;
    logic       done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_count;
    logic       rsp_err;

    logic [2:0] cnt_q = 3'd0;
    logic       done_stuck = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    counter_sequencer #(.WIDTH(3), .TIMEOUT(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_value (cmd_value),
        .load      (load),
        .in        (in_v),
        .inc       (inc),
        .done      (done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_err   (rsp_err)
    );

    // Counter being sequenced: done is a combinational decode of its registered count.
    always_ff @(posedge clock) begin
        if (load)     cnt_q <= in_v;
        else if (inc) cnt_q <= cnt_q + 3'd1;
    end
    assign done = !done_stuck && (cnt_q == 3'd7);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] v);
        @(negedge clock);
        check("push_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_value = v;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_load(input logic [2:0] v);
        int n = 0;
        @(negedge clock);
        while (!load && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("load_seen", 32'(load), 1);
        check("load_in", 32'(in_v), 32'(v));
    endtask

    // Called at the negedge where load is high; returns at the first RESP negedge.
    task automatic run_to_resp(input int ec, input logic ee, input int einc);
        int cycles = 0;
        int ninc   = 0;
        int both   = 0;
        while (!rsp_valid && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (inc) ninc++;
            if (load && inc) both++;
        end
        check("rsp_valid_rise", 32'(rsp_valid), 1);
        check("run_length", 32'(cycles - 1), ee ? 32'(12) : 32'(ec + 1));
        check("inc_cycles", 32'(ninc), 32'(einc));
        check("load_inc_overlap", 32'(both), 0);
        check("rsp_count", 32'(rsp_count), 32'(ec));
        check("rsp_err", 32'(rsp_err), 32'(ee));
    endtask

    task automatic handshake();
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        check("rsp_valid_drop", 32'(rsp_valid), 0);
    endtask

    initial begin
        int viol;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_value = 3'd0;
        rsp_ready = 1'b0;
        #12;
        check("rst_load", 32'(load), 0);
        check("rst_inc", 32'(inc), 0);
        check("rst_in", 32'(in_v), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_count", 32'(rsp_count), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clock);
        reset = 1'b1;

        // Value 0: latency from accept, then 7 increments.
        push(3'd0);
        @(negedge clock);
        check("idle_pop_no_load", 32'(load), 0);
        @(negedge clock);
        check("load_latency", 32'(load), 1);
        check("load_in_0", 32'(in_v), 0);
        run_to_resp(7, 1'b0, 7);
        handshake();

        // Value 7: done on the first RUN cycle.
        push(3'd7);
        wait_load(3'd7);
        run_to_resp(0, 1'b0, 0);
        handshake();

        // Stall in RESP while two more commands fill the queue.
        push(3'd4);
        wait_load(3'd4);
        run_to_resp(3, 1'b0, 3);
        push(3'd2);
        push(3'd5);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_value = 3'd6;
        check("third_push_blocked", 32'(cmd_ready), 0);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_count != 4'd3 || rsp_err || load || !(cmd_ready == 1'b0)) viol++;
        end
        cmd_valid = 1'b0;
        check("stall_stable", 32'(viol), 0);
        handshake();
        wait_load(3'd2);
        run_to_resp(5, 1'b0, 5);
        handshake();
        wait_load(3'd5);
        run_to_resp(2, 1'b0, 2);
        handshake();

        // Counter never reports done: timeout after 12 increments.
        done_stuck = 1'b1;
        push(3'd0);
        wait_load(3'd0);
        run_to_resp(12, 1'b1, 12);
        handshake();
        done_stuck = 1'b0;

        // Reset mid-RUN with one command queued.
        push(3'd1);
        wait_load(3'd1);
        push(3'd3);
        @(negedge clock);
        check("mid_run_inc", 32'(inc), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_inc", 32'(inc), 0);
        check("arst_load", 32'(load), 0);
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clock);
        reset = 1'b1;
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (load || rsp_valid || inc) viol++;
        end
        check("post_reset_quiet", 32'(viol), 0);
        check("post_reset_ready", 32'(cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
